// File: rtl/xor_parity_sched_pkg.sv
// Shared encodings for the serial XOR parity scheduler.
// Holds the FSM state type and the requester ID constants.
package xor_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/xor_parity_sched_if.sv
// Request/grant/result bundle between the two requesters and the scheduler.
// The master side drives requests and words; the slave side is the scheduler.
interface xor_parity_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             parity;
  logic             done_id;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, busy, done, parity, done_id
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, busy, done, parity, done_id
  );
endinterface

// File: rtl/xor2.sv
// Two-input XOR primitive of the gate-level datapath.
module xor2 (
  input  logic in1,
  input  logic in2,
  output logic out
);
  assign out = in1 ^ in2;
endmodule

// File: rtl/xor_parity_sched.sv
// Round-robin front-end sharing one xor2 between two requesters; computes
// the parity of the granted word serially, one bit per clock.
module xor_parity_sched #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  xor_parity_sched_if.slave bus
);
  import xor_sched_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic             acc_next;
  logic [CW-1:0]    cnt;
  logic             owner;
  logic             last;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done_q;
  logic             parity_q;
  logic             done_id_q;

  logic             win;
  logic [WIDTH-1:0] win_data;

  // The only XOR in the accumulation path.
  xor2 u_xor2 (
    .in1 (acc),
    .in2 (shreg[0]),
    .out (acc_next)
  );

  // Contention goes to whichever requester was not served last.
  always_comb begin
    win = ID_REQ0;
    if (bus.req0 && bus.req1) win = ~last;
    else if (bus.req1)        win = ID_REQ1;
    win_data = (win == ID_REQ1) ? bus.data1 : bus.data0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
      owner     <= ID_REQ0;
      last      <= ID_REQ1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            shreg  <= win_data;
            acc    <= 1'b0;
            cnt    <= '0;
            owner  <= win;
            gnt0_q <= (win == ID_REQ0);
            gnt1_q <= (win == ID_REQ1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          shreg <= shreg >> 1;
          // cnt is cleared on the final edge rather than incremented so it
          // stays within 0..WIDTH-1 for non-power-of-two widths.
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            done_q    <= 1'b1;
            parity_q  <= acc_next ^ ODD;
            done_id_q <= owner;
            last      <= owner;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = (state == SHIFT);
  assign bus.done    = done_q;
  assign bus.parity  = parity_q;
  assign bus.done_id = done_id_q;

endmodule

// File: doc/xor_parity_sched.md
Name: xor_parity_sched

Overview:
Shares one xor2 gate between two requesters to compute the parity of a WIDTH-bit word serially, one bit per clock.
- A round-robin scheduler grants one requester and captures its word.
- The word is shifted through a single xor2 instance used as the accumulator gate.
- When finished, the block emits a one-cycle done pulse carrying the result and the requester ID.
- It is the sequencing and arbitration front-end for the team's gate-level XOR datapath.

Parameters:
- WIDTH, 8, bits per word; legal range is WIDTH >= 1.
- ODD, 0, parity sense: 0 gives parity = XOR of all bits; 1 gives the inverted result.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high with data0 stable until granted.
- data0  input  WIDTH  requester 0 word.
- req1  input  1  requester 1 request.
- data1  input  WIDTH  requester 1 word.
- gnt0  output  1  one-cycle pulse: data0 captured.
- gnt1  output  1  one-cycle pulse: data1 captured.
- busy  output  1  high while a word is being shifted.
- done  output  1  one-cycle pulse: result valid.
- parity  output  1  result; valid while done=1 and held until the next done.
- done_id  output  1  owner of the result (0 or 1); valid while done=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and dominates all other inputs.
- Reset values: gnt0=gnt1=busy=done=parity=done_id=0; state=IDLE; last=1, so req0 wins the first contention.
- States: IDLE and SHIFT; busy = (state==SHIFT).
- Internal registers: shreg[WIDTH], acc, cnt (0..WIDTH-1, width max(1,clog2(WIDTH))), owner, last.
- IDLE, at capture edge E0 when any req is high:
  - Select the winner: if only one req is high, that one; if both, the one != last.
  - Load shreg <= winner's data, acc <= 0, cnt <= 0, owner <= winner.
  - Set gnt_winner <= 1, state <= SHIFT.
- IDLE with no req: everything holds and gnt stays 0.
- SHIFT, at edges E1..EWIDTH:
  - acc <= xor2(acc, shreg[0]), computed by the single xor2 instance.
  - shreg <= shreg >> 1; cnt <= cnt+1; gnt0 = gnt1 = 0.
  - req inputs are ignored.
- Completion, at edge EWIDTH (cnt == WIDTH-1):
  - done <= 1, parity <= xor2 output ^ ODD, done_id <= owner, last <= owner, state <= IDLE.
- done falls at the next edge.
- Latency:
  - gnt is high in the cycle after E0.
  - done is high in the cycle after EWIDTH, i.e. WIDTH edges after capture.
  - busy is high for WIDTH cycles.
- Throughput: one word per WIDTH+1 cycles. The edge EWIDTH+1 may capture a new request in the same edge that done falls.
- Requester rule: req must drop before edge EWIDTH+1. If req is still high there, it is treated as a new request and its word is re-served.
- Both requests held continuously: service strictly alternates 0,1,0,1...
- WIDTH=1: a single SHIFT edge; done appears the cycle after E1.
- Reset mid-SHIFT: the operation is abandoned with no done pulse. All outputs are 0 in the cycle after the reset edge, and last returns to 1.
- No arithmetic overflow: cnt never exceeds WIDTH-1.

Decomposition:
- Shared package/header xor_sched_pkg holds:
  - the state encodings (IDLE=1'b0, SHIFT=1'b1);
  - the requester ID constants (ID_REQ0=1'b0, ID_REQ1=1'b1).
- The one sub-module is the existing xor2, instantiated once with in1=acc, in2=shreg[0], out=acc_next. There is no other XOR logic in the accumulation path.
- Arbiter, shifter and counter are inline in xor_parity_sched.

Test Plan (WIDTH=8, ODD=0 unless noted):
1. Hold rst=1 for 2 cycles, then release with no req -> all outputs 0 for 10 cycles, busy never rises.
2. req0=1, data0=8'hA5 (4 ones) -> gnt0 high 1 cycle after capture; busy high 8 cycles; done=1 exactly 8 edges after capture with parity=0, done_id=0.
3. req1=1, data1=8'h07 (3 ones) -> gnt1 pulse; done with parity=1, done_id=1.
4. Right after reset, hold req0 and req1 high with data0=8'h01 and data1=8'h03 -> results come out in order (id0, parity 1), (id1, parity 0), (id0, parity 1). Each done is separated by 9 cycles, and the next gnt is coincident with the cycle after done's capture edge.
5. req0 with data0=8'hFF; assert rst for 1 cycle after the 4th SHIFT edge -> no done pulse; all outputs 0 next cycle. Then with req0 and req1 both high -> gnt0 first.
6. ODD=1, WIDTH=1, req0 with data0=1'b1 -> gnt0 in the cycle after capture; done the following cycle with parity=0, done_id=0.
